axi_stream_mux_nto1_pkt: RTL and testbench

//  Parametrised N:1 AXI-Stream multiplexer. Packet-aware: a granted input owns the output until its tlast beat.

---
 rtl/axi_stream_mux_nto1_pkt.sv | 217 +++++++++++++++++++++
 tb/tb_axi_stream_mux_nto1_pkt.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_mux_nto1_pkt.sv
// ---------------------------------------------------------------------------
// axi_stream_mux_nto1_pkt
//
// Packet-aware N:1 AXI-Stream multiplexer. A granted input keeps the output
// until its tlast beat has been accepted. Arbitration is either a fixed
// software select (ARB_MODE=0, sel port) or round-robin (ARB_MODE=1).
// The output side is a 2-entry skid buffer; tready_in is derived from a
// registered "space available" flag.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   sel         in   requested channel (ARB_MODE=0), sampled only in IDLE
//   tdata_in    in   packed channel data, channel k at [k*DATA_W +: DATA_W]
//   tvalid_in   in   per-channel valid
//   tlast_in    in   per-channel end-of-packet
//   tready_in   out  per-channel ready, at most one bit high
//   tdata_out   out  head-of-buffer data
//   tvalid_out  out  buffer not empty
//   tlast_out   out  head-of-buffer end-of-packet
//   tid_out     out  source channel of the head beat
//   tready_out  in   downstream ready
//
// FSM states
//   state  | meaning
//   IDLE   | no owner; candidate picked combinationally, first beat may be taken
//   LOCK   | channel grant_q owns the output until its tlast beat is accepted
// ---------------------------------------------------------------------------
module axi_stream_mux_nto1_pkt #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 1,
  parameter int SEL_W    = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH*DATA_W-1:0]   tdata_in,
  input  logic [N_CH-1:0]          tvalid_in,
  input  logic [N_CH-1:0]          tlast_in,
  output logic [N_CH-1:0]          tready_in,
  output logic [DATA_W-1:0]        tdata_out,
  output logic                     tvalid_out,
  output logic                     tlast_out,
  output logic [SEL_W-1:0]         tid_out,
  input  logic                     tready_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [1:0]        count_q, count_d;
  logic              space_q, space_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_last_q, head_last_d;
  logic [SEL_W-1:0]  head_tid_q, head_tid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic [SEL_W-1:0]  skid_tid_q, skid_tid_d;

  logic              cand_valid;
  logic [SEL_W-1:0]  cand_idx;
  logic              act_valid;
  logic [SEL_W-1:0]  act_idx;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  // Candidate selection for the IDLE state.
  always_comb begin
    int idx;
    cand_valid = 1'b0;
    cand_idx   = '0;
    idx        = 0;
    if (ARB_MODE == 0) begin
      // An out-of-range select never produces a grant.
      if (int'(sel) < N_CH) begin
        if (tvalid_in[sel]) begin
          cand_valid = 1'b1;
          cand_idx   = sel;
        end
      end
    end else begin
      // Search upward from the channel after rr_ptr, wrapping at N_CH-1.
      for (int i = 1; i <= N_CH; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!cand_valid && tvalid_in[idx]) begin
          cand_valid = 1'b1;
          cand_idx   = SEL_W'(idx);
        end
      end
    end
  end

  // In LOCK the owner is offered ready whether or not it is currently valid.
  always_comb begin
    if (state_q == S_IDLE) begin
      act_valid = cand_valid;
      act_idx   = cand_idx;
    end else begin
      act_valid = 1'b1;
      act_idx   = grant_q;
    end
  end

  always_comb begin
    tready_in = '0;
    if (act_valid && space_q) tready_in[act_idx] = 1'b1;
  end

  assign push    = act_valid && space_q && tvalid_in[act_idx];
  assign pop     = (count_q != 2'd0) && tready_out;
  assign in_data = tdata_in[int'(act_idx)*DATA_W +: DATA_W];
  assign in_last = tlast_in[act_idx];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      if (state_q == S_IDLE) begin
        rr_ptr_d = act_idx;
        if (!in_last) begin
          state_d = S_LOCK;
          grant_d = act_idx;
        end
      end else if (in_last) begin
        state_d = S_IDLE;
      end
    end
  end

  // Skid buffer: head registers drive the outputs, skid holds the second beat.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    head_tid_d  = head_tid_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_tid_d  = skid_tid_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = in_data;
          head_last_d = in_last;
          head_tid_d  = act_idx;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = in_data;
          head_last_d = in_last;
          head_tid_d  = act_idx;
        end else if (push) begin
          skid_data_d = in_data;
          skid_last_d = in_last;
          skid_tid_d  = act_idx;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: space_q is low, so no push can coincide here.
        if (pop) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
          head_tid_d  = skid_tid_q;
          count_d     = 2'd1;
        end
      end
    endcase
    space_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      count_q     <= 2'd0;
      space_q     <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      head_tid_q  <= '0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_tid_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      space_q     <= space_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      head_tid_q  <= head_tid_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_tid_q  <= skid_tid_d;
    end
  end

  assign tvalid_out = (count_q != 2'd0);
  assign tdata_out  = head_data_q;
  assign tlast_out  = head_last_q;
  assign tid_out    = head_tid_q;

endmodule

// File: tb/tb_axi_stream_mux_nto1_pkt.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_mux_nto1_pkt
//
// Directed bench for the packet-aware stream mux. Two instances share one set
// of input drivers: a round-robin one and a fixed-select one; use_fx chooses
// which instance the bench sources and output recorder talk to.
// ---------------------------------------------------------------------------
module tb_axi_stream_mux_nto1_pkt;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] tdata_in = '0;
  logic [N-1:0]  tvalid_in = '0;
  logic [N-1:0]  tlast_in = '0;
  logic          tready_out = 1'b1;
  logic          use_fx = 1'b0;

  logic [N-1:0]  rr_tready_in, fx_tready_in;
  logic [W-1:0]  rr_tdata, fx_tdata;
  logic          rr_tvalid, fx_tvalid;
  logic          rr_tlast, fx_tlast;
  logic [SW-1:0] rr_tid, fx_tid;

  axi_stream_mux_nto1_pkt #(.N_CH(N), .DATA_W(W), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .sel(sel), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tready_in(rr_tready_in), .tdata_out(rr_tdata),
    .tvalid_out(rr_tvalid), .tlast_out(rr_tlast), .tid_out(rr_tid), .tready_out(tready_out));

  axi_stream_mux_nto1_pkt #(.N_CH(N), .DATA_W(W), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .sel(sel), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tready_in(fx_tready_in), .tdata_out(fx_tdata),
    .tvalid_out(fx_tvalid), .tlast_out(fx_tlast), .tid_out(fx_tid), .tready_out(tready_out));

  logic [N-1:0]  m_tready_in;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid, m_tlast;
  logic [SW-1:0] m_tid;
  assign m_tready_in = use_fx ? fx_tready_in : rr_tready_in;
  assign m_tdata     = use_fx ? fx_tdata     : rr_tdata;
  assign m_tvalid    = use_fx ? fx_tvalid    : rr_tvalid;
  assign m_tlast     = use_fx ? fx_tlast     : rr_tlast;
  assign m_tid       = use_fx ? fx_tid       : rr_tid;

  // Per-channel beat sources.
  logic [W-1:0] s_data [N][16];
  logic         s_last [N][16];
  int           s_len  [N];
  int           s_idx  [N];

  // Recorded output beats.
  logic [W-1:0]  o_data [64];
  logic [SW-1:0] o_tid  [64];
  logic          o_last [64];
  int            o_cyc  [64];
  int            n_out = 0;
  int            cyc = 0;

  logic          hold_pend = 1'b0;
  logic [W-1:0]  hold_data;
  logic [SW-1:0] hold_tid;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      if (s_idx[k] < s_len[k]) begin
        tvalid_in[k]          = 1'b1;
        tdata_in[k*W +: W]    = s_data[k][s_idx[k]];
        tlast_in[k]           = s_last[k][s_idx[k]];
      end else begin
        tvalid_in[k]          = 1'b0;
        tdata_in[k*W +: W]    = '0;
        tlast_in[k]           = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      s_len[k] = 0;
      s_idx[k] = 0;
    end
    drive_src();
  endtask

  task automatic add_beat(input int ch, input logic [W-1:0] d, input logic l);
    s_data[ch][s_len[ch]] = d;
    s_last[ch][s_len[ch]] = l;
    s_len[ch]++;
  endtask

  // One clock: sample at the falling edge, advance sources after the rising edge.
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = tvalid_in & m_tready_in;
    if (!rst) begin
      check("ready_onehot0", 64'($onehot0(m_tready_in)), 64'd1);
      if (hold_pend) begin
        check("hold_valid", 64'(m_tvalid), 64'd1);
        check("hold_data", 64'(m_tdata), 64'(hold_data));
        check("hold_tid", 64'(m_tid), 64'(hold_tid));
      end
      if (m_tvalid && tready_out && n_out < 64) begin
        o_data[n_out] = m_tdata;
        o_tid[n_out]  = m_tid;
        o_last[n_out] = m_tlast;
        o_cyc[n_out]  = cyc;
        n_out++;
      end
    end
    hold_pend = m_tvalid && !tready_out && !rst;
    hold_data = m_tdata;
    hold_tid  = m_tid;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      for (int k = 0; k < N; k++) if (acc[k]) s_idx[k]++;
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    cycle();
    cycle();
    rst = 1'b0;
    hold_pend = 1'b0;
    n_out = 0;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (n_out < n && b < budget) begin
      cycle();
      b++;
    end
    check(tag, 64'(n_out >= n), 64'd1);
  endtask

  initial begin
    int b;
    int r, ch;
    for (int k = 0; k < N; k++) begin
      s_len[k] = 0;
      s_idx[k] = 0;
    end

    // T1: reset with every channel valid.
    rst = 1'b1;
    tready_out = 1'b1;
    for (int k = 0; k < N; k++) add_beat(k, 32'(k), 1'b1);
    drive_src();
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t1_rr_tvalid", 64'(rr_tvalid), 64'd0);
      check("t1_rr_tready_in", 64'(rr_tready_in), 64'd0);
      check("t1_rr_tid", 64'(rr_tid), 64'd0);
      check("t1_fx_tvalid", 64'(fx_tvalid), 64'd0);
      check("t1_fx_tready_in", 64'(fx_tready_in), 64'd0);
      check("t1_fx_tdata", 64'(fx_tdata), 64'd0);
    end

    // T2: round-robin over four channels, two 2-beat packets each.
    use_fx = 1'b0;
    do_reset();
    for (int k = 0; k < N; k++) begin
      add_beat(k, 32'(k*16 + 0), 1'b0);
      add_beat(k, 32'(k*16 + 1), 1'b1);
      add_beat(k, 32'(k*16 + 2), 1'b0);
      add_beat(k, 32'(k*16 + 3), 1'b1);
    end
    drive_src();
    wait_out(16, 100, "t2_timeout");
    for (int i = 0; i < 16; i++) begin
      r  = i / 8;
      ch = (i % 8) / 2;
      check("t2_tid", 64'(o_tid[i]), 64'(ch));
      check("t2_data", 64'(o_data[i]), 64'(ch*16 + r*2 + i%2));
      check("t2_last", 64'(o_last[i]), 64'(i % 2));
    end
    check("t2_rate", 64'(o_cyc[15] - o_cyc[0]), 64'd15);

    // T3: fixed select, packet lock survives a sel change.
    use_fx = 1'b1;
    sel = 2'd1;
    do_reset();
    add_beat(1, 32'h96, 1'b0);
    add_beat(1, 32'h97, 1'b0);
    add_beat(1, 32'h98, 1'b0);
    add_beat(1, 32'h99, 1'b1);
    add_beat(0, 32'h45, 1'b1);
    drive_src();
    b = 0;
    while (s_idx[1] < 2 && b < 20) begin
      cycle();
      b++;
    end
    check("t3_start", 64'(s_idx[1] >= 2), 64'd1);
    sel = 2'd0;
    wait_out(5, 40, "t3_timeout");
    check("t3_tid0", 64'(o_tid[0]), 64'd1);
    check("t3_d0", 64'(o_data[0]), 64'h96);
    check("t3_tid1", 64'(o_tid[1]), 64'd1);
    check("t3_d1", 64'(o_data[1]), 64'h97);
    check("t3_tid2", 64'(o_tid[2]), 64'd1);
    check("t3_d2", 64'(o_data[2]), 64'h98);
    check("t3_tid3", 64'(o_tid[3]), 64'd1);
    check("t3_d3", 64'(o_data[3]), 64'h99);
    check("t3_last3", 64'(o_last[3]), 64'd1);
    check("t3_tid4", 64'(o_tid[4]), 64'd0);
    check("t3_d4", 64'(o_data[4]), 64'h45);

    // T4: backpressure mid-packet on channel 2.
    use_fx = 1'b0;
    tready_out = 1'b1;
    do_reset();
    add_beat(2, 32'h76, 1'b0);
    add_beat(2, 32'h77, 1'b0);
    add_beat(2, 32'h78, 1'b0);
    add_beat(2, 32'h79, 1'b0);
    add_beat(2, 32'h7A, 1'b1);
    drive_src();
    b = 0;
    while (!(m_tvalid && m_tdata == 32'h78) && b < 20) begin
      cycle();
      b++;
    end
    check("t4_reach78", 64'(m_tvalid && m_tdata == 32'h78), 64'd1);
    tready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_tready_in", 64'(m_tready_in), 64'd0);
      check("t4_tvalid", 64'(m_tvalid), 64'd1);
      check("t4_tdata", 64'(m_tdata), 64'h78);
    end
    check("t4_src_taken", 64'(s_idx[2]), 64'd4);
    tready_out = 1'b1;
    wait_out(5, 20, "t4_timeout");
    repeat (3) cycle();
    check("t4_count", 64'(n_out), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check("t4_data", 64'(o_data[i]), 64'(32'h76 + i));
      check("t4_tid", 64'(o_tid[i]), 64'd2);
    end

    // T5: single-beat packets on channels 2 and 3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_beat(2, 32'(32'hA0 + i), 1'b1);
      add_beat(3, 32'(32'hB0 + i), 1'b1);
    end
    drive_src();
    wait_out(8, 40, "t5_timeout");
    for (int i = 0; i < 8; i++) begin
      check("t5_tid", 64'(o_tid[i]), 64'(2 + i % 2));
      check("t5_data", 64'(o_data[i]), 64'((i % 2 == 0 ? 32'hA0 : 32'hB0) + i / 2));
    end
    check("t5_rate", 64'(o_cyc[7] - o_cyc[0]), 64'd7);

    // T6: reset in the middle of a 4-beat packet.
    do_reset();
    add_beat(1, 32'h50, 1'b0);
    add_beat(1, 32'h51, 1'b0);
    add_beat(1, 32'h52, 1'b0);
    add_beat(1, 32'h53, 1'b1);
    drive_src();
    b = 0;
    while (s_idx[1] < 2 && b < 20) begin
      cycle();
      b++;
    end
    check("t6_start", 64'(s_idx[1] >= 2), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    hold_pend = 1'b0;
    clear_src();
    check("t6_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_tready_in", 64'(m_tready_in), 64'd0);
    n_out = 0;
    add_beat(0, 32'h60, 1'b1);
    add_beat(2, 32'h62, 1'b1);
    drive_src();
    wait_out(2, 20, "t6_timeout");
    check("t6_tid0", 64'(o_tid[0]), 64'd0);
    check("t6_d0", 64'(o_data[0]), 64'h60);
    check("t6_tid1", 64'(o_tid[1]), 64'd2);
    check("t6_d1", 64'(o_data[1]), 64'h62);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
